// File: rtl/sequential_carry_select_adder.sv
// Multi-cycle adder: one carry-select slice per clock, LSB slice first.
// Slice carry is kept in a register and selects the precomputed slice result.
module carry_select_adder_rca_N_block #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         select,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0]   c0;
  logic [N:0]   c1;
  logic [N-1:0] s0;
  logic [N-1:0] s1;

  // Two ripple chains, one per assumed carry-in.
  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c0[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c0[i]);
      c1[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c1[i]);
    end
  end

  assign sum  = select ? s1 : s0;
  assign cout = select ? c1[N] : c0[N];
endmodule

module sequential_carry_select_adder #(
  parameter int N      = 4,
  parameter int BLOCKS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*BLOCKS-1:0] a,
  input  logic [N*BLOCKS-1:0] b,
  input  logic            cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*BLOCKS-1:0] sum,
  output logic            cout,
  output logic            busy
);
  localparam int W  = N * BLOCKS;
  localparam int IW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [N-1:0]  slice_sum;
  logic          slice_cout;
  logic          last;

  assign last = (idx == IW'(BLOCKS - 1));

  carry_select_adder_rca_N_block #(
    .N (N)
  ) u_slice (
    .a      (a_q[idx*N +: N]),
    .b      (b_q[idx*N +: N]),
    .select (carry),
    .sum    (slice_sum),
    .cout   (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*N +: N] <= slice_sum;
          carry           <= slice_cout;
          if (last) begin
            cout  <= slice_cout;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
endmodule

// File: tb/tb_sequential_carry_select_adder.sv
// Bench for sequential_carry_select_adder: transaction model plus
// directed vectors, 16-bit (4x4) and 8-bit single-slice instances.
module tb_sequential_carry_select_adder;
  localparam int B = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;

  logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2;
  logic       cout2, busy2;
  logic [7:0] a2, b2, sum2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sequential_carry_select_adder #(.N(4), .BLOCKS(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  sequential_carry_select_adder #(.N(8), .BLOCKS(1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: accept, B cycles of work, then hold until taken.
  bit          m_idle;
  bit          m_done;
  int          m_left;
  logic [15:0] m_sum;
  logic        m_cout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1; m_done = 0; m_left = 0;
      m_sum  = '0; m_cout = 0;
    end else if (m_idle && in_valid) begin
      {m_cout, m_sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      m_idle = 0;
      m_left = B;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (m_done && out_ready) begin
      m_done = 0;
      m_idle = 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, m_idle);
      chk("busy", busy, m_left > 0);
      chk("out_valid", out_valid, m_done);
      if (m_done) begin
        chk("sum", sum, m_sum);
        chk("cout", cout, m_cout);
      end
    end
  end

  task automatic start_op(input logic [15:0] x, input logic [15:0] y,
                          input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = busy ? 1 : 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
    end
    if (!out_valid) chk("timeout_out_valid", 0, 1);
  endtask

  task automatic release_result();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("in_ready_after_take", in_ready, 1);
    chk("out_valid_after_take", out_valid, 0);
  endtask

  int lat, nb;

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0;
    in_valid2 = 0; out_ready2 = 0; a2 = '0; b2 = '0; cin2 = 0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    start_op(16'hFFFF, 16'h0001, 0);
    wait_done(lat, nb);
    chk("ovf_latency", lat, 4);
    chk("ovf_sum", sum, 16'h0000);
    chk("ovf_cout", cout, 1);
    release_result();

    start_op(16'h1234, 16'h4321, 1);
    wait_done(lat, nb);
    chk("mix_sum", sum, 16'h5556);
    chk("mix_cout", cout, 0);
    chk("mix_busy_cycles", nb, 4);
    chk("model_sum", m_sum, 16'h5556);
    release_result();

    start_op(16'h00FF, 16'h0001, 0);
    wait_done(lat, nb);
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, 16'h0100);
      chk("hold_cout", cout, 0);
      chk("hold_in_ready", in_ready, 0);
    end
    release_result();

    start_op(16'h0F0F, 16'h00F1, 0);
    a = 16'hAAAA; b = 16'h5555; cin = 1; in_valid = 1;
    wait_done(lat, nb);
    in_valid = 0;
    chk("ign_sum", sum, 16'h1000);
    chk("ign_cout", cout, 0);
    chk("ign_latency", lat, 4);
    release_result();

    start_op(16'h1111, 16'h2222, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 16'h0000);
    chk("abort_cout", cout, 0);
    @(negedge clk);
    a = 16'h8000; b = 16'h8000; cin = 0; in_valid = 1;
    rst_n = 1;
    @(negedge clk);
    in_valid = 0;
    wait_done(lat, nb);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_sum", sum, 16'h0000);
    chk("post_rst_cout", cout, 1);
    release_result();

    for (int i = 0; i < 6; i++) begin
      start_op(16'($urandom), 16'($urandom), 1'($urandom));
      wait_done(lat, nb);
      release_result();
    end

    @(negedge clk);
    a2 = 8'hFF; b2 = 8'hFF; cin2 = 1; in_valid2 = 1;
    @(negedge clk);
    in_valid2 = 0;
    chk("b1_busy", busy2, 1);
    chk("b1_out_valid_early", out_valid2, 0);
    @(negedge clk);
    chk("b1_out_valid", out_valid2, 1);
    chk("b1_sum", sum2, 8'hFF);
    chk("b1_cout", cout2, 1);
    out_ready2 = 1;
    @(negedge clk);
    out_ready2 = 0;
    chk("b1_in_ready", in_ready2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sequential_carry_select_adder.md
SEQUENTIAL_CARRY_SELECT_ADDER -- requirements
Module: sequential_carry_select_adder

Interface
REQ-001 SHALL have parameter N, default 4: bit width of one carry-select slice.
REQ-002 SHALL have parameter BLOCKS, default 4, minimum 1: number of slices per operand; W = N*BLOCKS.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operands and cin are valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port a, input, W: operand A.
REQ-008 SHALL have port b, input, W: operand B.
REQ-009 SHALL have port cin, input, 1: carry into slice 0.
REQ-010 SHALL have port out_valid, output, 1: sum and cout are valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port sum, output, W: registered result a+b+cin modulo 2^W.
REQ-013 SHALL have port cout, output, 1: carry out of the top slice.
REQ-014 SHALL have port busy, output, 1: high in RUN state.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE), out_valid = (state==DONE), busy = (state==RUN).
REQ-016 SHALL accept on the edge where in_valid && in_ready: latch a, b; carry register <= cin; slice index <= 0; state -> RUN.
REQ-017 SHALL instantiate exactly one carry_select_adder_rca_N_block of width N, driven by slice[idx] of latched a and b, with select = carry register.
REQ-018 SHALL, on each RUN edge, write the slice sum into sum[idx*N +: N], load the slice cout into the carry register, and increment idx.
REQ-019 SHALL, on the RUN edge processing idx = BLOCKS-1, load cout from the slice cout and move to DONE; idx does not wrap beyond BLOCKS-1.
REQ-020 SHALL raise out_valid on the BLOCKS-th rising edge after the accept edge (BLOCKS=1: the first edge after accept).
REQ-021 SHALL hold sum, cout, out_valid stable in DONE while out_ready is low.
REQ-022 SHALL return to IDLE on the edge where out_valid && out_ready; in_ready rises after that edge (no same-cycle accept in DONE).
REQ-023 SHALL ignore in_valid, a, b, cin outside IDLE; latched operands are unaffected by input changes during RUN/DONE.
REQ-024 SHALL leave sum slices not yet processed at their previous values during RUN; only DONE values are guaranteed.
REQ-025 SHALL treat out_ready as don't-care outside DONE.

Reset
REQ-026 SHALL, while rst_n is low, force state IDLE, idx 0, carry register 0, sum 0, cout 0, latched operands 0, independent of clk.
REQ-027 SHALL output in_ready=1, out_valid=0, busy=0 during and immediately after reset.
REQ-028 SHALL abort any operation in RUN or DONE on reset assertion; no result is presented after reset release.
REQ-029 SHALL accept a new operation on the first edge after rst_n deasserts if in_valid is high.

Verification (N=4, BLOCKS=4 unless stated)
REQ-030 SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 edges after accept, sum=0x0000, cout=1.
REQ-031 SHALL cover: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; busy high for exactly 4 cycles.
REQ-032 SHALL cover: out_ready low 3 cycles in DONE -> sum/cout/out_valid stable; in_ready stays 0; IDLE one edge after out_ready=1.
REQ-033 SHALL cover: in_valid high with a=0xAAAA during RUN of 0x0F0F+0x00F1 -> ignored; result sum=0x1000, cout=0.
REQ-034 SHALL cover: rst_n pulsed low at RUN idx=2 -> immediately in_ready=1, out_valid=0, sum=0, cout=0; next op 0x8000+0x8000 -> sum=0x0000, cout=1.
REQ-035 SHALL cover: BLOCKS=1, N=8, a=0xFF, b=0xFF, cin=1 -> out_valid one edge after accept, sum=0xFF, cout=1.
